// File: rtl/project_types.sv
// Shared types and constants for the memory-bus arbiter.
package project_types;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      MEM_BUSY   = 2'd1,
      IF_BUSY    = 2'd2,
      IF_DISCARD = 2'd3
   } bus_arb_state_t;

   localparam logic RST_ENABLE          = 1'b1;
   localparam logic CHIP_ENABLE         = 1'b1;
   localparam int   BUS_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Busy-cycle counter that pulses expired when a transaction has waited TIMEOUT_CYC cycles.
module bus_watchdog #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Terminal count is reached during the TIMEOUT_CYC-th unacknowledged busy cycle.
   assign expired = count_en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear || expired) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one req/ack memory bus between the IF and MEM pipeline stages, MEM first,
// holding each result until consumed and aborting hung transactions via a watchdog.
module bus_arbiter
   import project_types::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = BUS_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          stall,
   input  logic                flush,
   input  logic                if_en,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_data,
   output logic                if_stallreq,
   input  logic                mem_en,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_sel,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_stallreq,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                bus_err
);

   localparam int SEL_W = DATA_W / 8;

   bus_arb_state_t    state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              bus_err_q, bus_err_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic              wd_clear, wd_count, wd_expired;
   logic              unused_stall_bits;

   assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

   assign wd_count = (state_q != IDLE) && !bus_ack;
   assign wd_clear = (state_d != IDLE) && (state_d != state_q);

   bus_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .count_en(wd_count),
      .expired (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_err_d   = bus_err_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = if_done_q;
      mem_done_d  = mem_done_q;

      // Consumption first so that a completion on the same edge sets the flag again.
      if (!stall[4]) mem_done_d = 1'b0;
      if (!stall[1] || flush) if_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mem_en && !mem_done_q) begin
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we;
               bus_sel_d   = mem_sel;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               state_d     = MEM_BUSY;
            end else if (if_en && !if_done_q && !flush) begin
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_sel_d  = '1;
               bus_addr_d = if_addr;
               state_d    = IF_BUSY;
            end
         end
         MEM_BUSY: begin
            if (bus_ack) begin
               if (!bus_we_q) mem_rdata_d = bus_rdata;
               mem_done_d = 1'b1;
               bus_req_d  = 1'b0;
               state_d    = IDLE;
            end else if (wd_expired) begin
               mem_rdata_d = '0;
               mem_done_d  = 1'b1;
               bus_req_d   = 1'b0;
               bus_err_d   = 1'b1;
               state_d     = IDLE;
            end
         end
         IF_BUSY: begin
            if (bus_ack) begin
               if (!flush) begin
                  if_data_d = bus_rdata;
                  if_done_d = 1'b1;
               end
               bus_req_d = 1'b0;
               state_d   = IDLE;
            end else if (flush) begin
               // The bus has no abort, so the killed fetch must still run to its ack.
               state_d = IF_DISCARD;
            end else if (wd_expired) begin
               if_data_d = '0;
               if_done_d = 1'b1;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         IF_DISCARD: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = IDLE;
            end else if (wd_expired) begin
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_err_q   <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
      end
   end

   assign if_stallreq  = !rst && if_en && !if_done_q;
   assign mem_stallreq = !rst && mem_en && !mem_done_q;
   assign if_data      = if_data_q;
   assign mem_rdata    = mem_rdata_q;
   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_sel      = bus_sel_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario bench for bus_arbiter: directed cases plus randomized single transactions
// scored against expected bus fields, latency and result data.
module tb_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          if_en;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_data;
   logic          if_stallreq;
   logic          mem_en;
   logic          mem_we;
   logic [3:0]    mem_sel;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_stallreq;
   logic          bus_req;
   logic          bus_we;
   logic [3:0]    bus_sel;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_ack;
   logic [DW-1:0] bus_rdata;
   logic          bus_err;

   int checks = 0;
   int errors = 0;

   // Slave model: acks on busy cycle ws+1 with slv_data.
   int            ws = 0;
   int            busy_cnt = 0;
   logic [DW-1:0] slv_data = '0;
   logic          force_ack = 1'b0;

   logic [DW-1:0] exp_if  = '0;
   logic [DW-1:0] exp_mem = '0;

   bus_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_en(if_en), .if_addr(if_addr), .if_data(if_data), .if_stallreq(if_stallreq),
      .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
      .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (force_ack) begin
         bus_ack = 1'b1; bus_rdata = slv_data;
      end else if (bus_req) begin
         busy_cnt++;
         if (busy_cnt == ws + 1) begin bus_ack = 1'b1; bus_rdata = slv_data; end
         else begin bus_ack = 1'b0; bus_rdata = '0; end
      end else begin
         busy_cnt = 0; bus_ack = 1'b0; bus_rdata = '0;
      end
   endtask

   task automatic test_reset();
      if_en = 1'b1; mem_en = 1'b1;
      tick(); tick();
      checks++; if (if_stallreq !== 1'b0) begin errors++; $display("FAIL rst_if_stallreq got %b exp 0", if_stallreq); end
      checks++; if (mem_stallreq !== 1'b0) begin errors++; $display("FAIL rst_mem_stallreq got %b exp 0", mem_stallreq); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b exp 0", bus_req); end
      checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we got %b exp 0", bus_we); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
      checks++; if (bus_sel !== 4'h0) begin errors++; $display("FAIL rst_bus_sel got %h exp 0", bus_sel); end
      checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr got %h exp 0", bus_addr); end
      checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_bus_wdata got %h exp 0", bus_wdata); end
      checks++; if (if_data !== 32'h0) begin errors++; $display("FAIL rst_if_data got %h exp 0", if_data); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_mem_rdata got %h exp 0", mem_rdata); end
      if_en = 1'b0; mem_en = 1'b0;
      @(negedge clk); rst = 1'b0;
      tick();
   endtask

   task automatic test_zero_wait_fetch();
      ws = 0; slv_data = 32'h2402_0005; if_addr = 32'h40; if_en = 1'b1;
      tick();
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL zw_bus_req got %b exp 1", bus_req); end
      checks++; if (bus_addr !== 32'h40) begin errors++; $display("FAIL zw_bus_addr got %h exp 00000040", bus_addr); end
      checks++; if (bus_we !== 1'b0 || bus_sel !== 4'hF) begin errors++; $display("FAIL zw_we_sel got %b/%h exp 0/f", bus_we, bus_sel); end
      checks++; if (if_stallreq !== 1'b1) begin errors++; $display("FAIL zw_stall_c1 got %b exp 1", if_stallreq); end
      tick();
      exp_if = 32'h2402_0005;
      checks++; if (if_data !== exp_if) begin errors++; $display("FAIL zw_if_data got %h exp %h", if_data, exp_if); end
      checks++; if (if_stallreq !== 1'b0) begin errors++; $display("FAIL zw_stall_c2 got %b exp 0", if_stallreq); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL zw_req_c2 got %b exp 0", bus_req); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      ws = 0; slv_data = 32'h0000_1234;
      if_en = 1'b1; if_addr = 32'h80;
      mem_en = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hBEEF;
      tick();
      checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL ct_mem_first got req %b we %b exp 1 1", bus_req, bus_we); end
      checks++; if (bus_addr !== 32'h100 || bus_sel !== 4'b0011 || bus_wdata !== 32'hBEEF) begin
         errors++; $display("FAIL ct_mem_fields got %h/%h/%h exp 00000100/3/0000beef", bus_addr, bus_sel, bus_wdata); end
      checks++; if (if_stallreq !== 1'b1) begin errors++; $display("FAIL ct_if_stall_c1 got %b exp 1", if_stallreq); end
      tick();
      checks++; if (mem_stallreq !== 1'b0) begin errors++; $display("FAIL ct_mem_stall_c2 got %b exp 0", mem_stallreq); end
      checks++; if (mem_rdata !== exp_mem) begin errors++; $display("FAIL ct_write_keeps_rdata got %h exp %h", mem_rdata, exp_mem); end
      checks++; if (if_stallreq !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL ct_c2 got ifst %b req %b exp 1 0", if_stallreq, bus_req); end
      mem_en = 1'b0;
      tick();
      checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h80 || bus_we !== 1'b0 || bus_sel !== 4'hF) begin
         errors++; $display("FAIL ct_fetch_c3 got req %b addr %h we %b sel %h", bus_req, bus_addr, bus_we, bus_sel); end
      checks++; if (if_stallreq !== 1'b1) begin errors++; $display("FAIL ct_if_stall_c3 got %b exp 1", if_stallreq); end
      tick();
      exp_if = 32'h0000_1234;
      checks++; if (if_stallreq !== 1'b0 || if_data !== exp_if) begin errors++; $display("FAIL ct_fetch_c4 got st %b data %h exp 0 %h", if_stallreq, if_data, exp_if); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_flush_discard();
      ws = 3; slv_data = 32'h1111_1111; if_addr = 32'h200; if_en = 1'b1;
      tick();
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fl_req_c1 got %b exp 1", bus_req); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fl_req_c2 got %b exp 1", bus_req); end
      checks++; if (if_stallreq !== 1'b1) begin errors++; $display("FAIL fl_stall_c2 got %b exp 1", if_stallreq); end
      tick();
      tick();
      checks++; if (bus_req !== 1'b1 || bus_ack !== 1'b1) begin errors++; $display("FAIL fl_req_held_to_ack got req %b ack %b exp 1 1", bus_req, bus_ack); end
      tick();
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fl_req_c5 got %b exp 0", bus_req); end
      checks++; if (if_data !== exp_if) begin errors++; $display("FAIL fl_data_dropped got %h exp %h", if_data, exp_if); end
      checks++; if (if_stallreq !== 1'b1) begin errors++; $display("FAIL fl_stall_c5 got %b exp 1", if_stallreq); end
      ws = 0; slv_data = 32'h2222_2222; if_addr = 32'h204;
      tick();
      checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h204) begin errors++; $display("FAIL fl_reissue got req %b addr %h exp 1 00000204", bus_req, bus_addr); end
      tick();
      exp_if = 32'h2222_2222;
      checks++; if (if_data !== exp_if || if_stallreq !== 1'b0) begin errors++; $display("FAIL fl_refetch got %h st %b exp %h 0", if_data, if_stallreq, exp_if); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_consume_hold();
      ws = 1; slv_data = 32'hCAFE_F00D; stall = 6'b010000;
      mem_en = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
      tick(); tick(); tick();
      exp_mem = 32'hCAFE_F00D;
      checks++; if (mem_rdata !== exp_mem || mem_stallreq !== 1'b0) begin errors++; $display("FAIL ch_load got %h st %b exp %h 0", mem_rdata, mem_stallreq, exp_mem); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_rdata !== exp_mem || mem_stallreq !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL ch_hold%0d got data %h st %b req %b", i, mem_rdata, mem_stallreq, bus_req); end
      end
      stall = 6'b000000;
      tick();
      checks++; if (mem_stallreq !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL ch_consumed got st %b req %b exp 1 0", mem_stallreq, bus_req); end
      mem_en = 1'b0;
      tick();
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ch_no_reissue got %b exp 0", bus_req); end
   endtask

   task automatic test_random();
      int            kind, lat;
      logic [AW-1:0] a;
      logic [DW-1:0] d, wd;
      logic [3:0]    s;
      logic          st;
      for (int t = 0; t < 30; t++) begin
         kind = int'($urandom_range(0, 2));
         a = $urandom; d = $urandom; wd = $urandom;
         s = 4'($urandom_range(1, 15));
         ws = int'($urandom_range(0, 3)); slv_data = d;
         if (kind == 0) begin
            if_addr = a; if_en = 1'b1;
         end else begin
            mem_en = 1'b1; mem_we = (kind == 2); mem_addr = a; mem_sel = s; mem_wdata = wd;
         end
         lat = 0;
         for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
               checks++; if (bus_req !== 1'b1 || bus_addr !== a) begin errors++; $display("FAIL rnd%0d_issue got req %b addr %h exp 1 %h", t, bus_req, bus_addr, a); end
               checks++; if (bus_we !== (kind == 2) || bus_sel !== ((kind == 0) ? 4'hF : s)) begin
                  errors++; $display("FAIL rnd%0d_we_sel got %b/%h kind %0d", t, bus_we, bus_sel, kind); end
               if (kind == 2) begin
                  checks++; if (bus_wdata !== wd) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", t, bus_wdata, wd); end
               end
            end
            st = (kind == 0) ? if_stallreq : mem_stallreq;
            if (st == 1'b0) begin lat = c; break; end
         end
         checks++; if (lat != ws + 2) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", t, lat, ws + 2); end
         if (kind == 0) exp_if = d;
         else if (kind == 1) exp_mem = d;
         checks++; if (if_data !== exp_if || mem_rdata !== exp_mem) begin
            errors++; $display("FAIL rnd%0d_result got if %h mem %h exp %h %h", t, if_data, mem_rdata, exp_if, exp_mem); end
         if_en = 1'b0; mem_en = 1'b0;
         tick();
      end
   endtask

   task automatic test_watchdog();
      int n_busy;
      ws = 1000; mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; mem_sel = 4'hF;
      n_busy = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (!bus_req) break;
         n_busy++;
      end
      checks++; if (n_busy != 8) begin errors++; $display("FAIL wd_busy_cycles got %0d exp 8", n_busy); end
      exp_mem = '0;
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL wd_err got %b exp 1", bus_err); end
      checks++; if (mem_rdata !== exp_mem || mem_stallreq !== 1'b0) begin errors++; $display("FAIL wd_result got %h st %b exp 0 0", mem_rdata, mem_stallreq); end
      mem_en = 1'b0;
      ws = 0; slv_data = 32'h0000_55AA; if_addr = 32'h500; if_en = 1'b1;
      tick(); tick();
      exp_if = 32'h0000_55AA;
      checks++; if (if_data !== exp_if) begin errors++; $display("FAIL wd_next_fetch got %h exp %h", if_data, exp_if); end
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL wd_err_sticky got %b exp 1", bus_err); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      ws = 5; slv_data = 32'hDEAD_BEEF;
      mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; mem_sel = 4'hF;
      tick();
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ar_busy got %b exp 1", bus_req); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ar_req_drop got %b exp 0", bus_req); end
      checks++; if (mem_stallreq !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL ar_ctl got st %b err %b exp 0 0", mem_stallreq, bus_err); end
      checks++; if (if_data !== 32'h0 || mem_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_sel !== 4'h0) begin
         errors++; $display("FAIL ar_data got %h %h %h %h exp 0", if_data, mem_rdata, bus_addr, bus_sel); end
      mem_en = 1'b0;
      @(negedge clk); rst = 1'b0;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      tick();
      checks++; if (mem_rdata !== 32'h0 || if_data !== 32'h0 || bus_req !== 1'b0) begin
         errors++; $display("FAIL ar_late_ack got mem %h if %h req %b exp 0 0 0", mem_rdata, if_data, bus_req); end
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0;
      if_en = 1'b0; if_addr = '0;
      mem_en = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      test_reset();
      test_zero_wait_fetch();
      test_contention();
      test_flush_discard();
      test_consume_hold();
      test_random();
      test_watchdog();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "bench time limit reached");
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one external memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). It sequences single transactions over a req/ack bus with variable slave latency, and holds each stage's result until the pipeline consumes it. It raises per-stage stall requests to the pipeline controller and discards fetches killed by a flush. A watchdog terminates hung transactions. The block sits between the PC/IF stage, the MEM stage and the off-chip SRAM/ROM port.

## Interface
- `ADDR_W`, 32, bus/requester address width
- `DATA_W`, 32, data width; `DATA_W/8` byte selects
- `TIMEOUT_CYC`, 255, cycles without ack before abort (≥2)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high (`RST_ENABLE`=1)
- `stall`  in  6  pipeline stall vector; `stall[1]` = IF hold, `stall[4]` = MEM hold
- `flush`  in  1  pipeline flush; kills the IF request in flight
- `if_en`  in  1  IF fetch request, held until served
- `if_addr`  in  ADDR_W  fetch address
- `if_data`  out  DATA_W  fetched word
- `if_stallreq`  out  1  IF result not yet available
- `mem_en`  in  1  MEM access request, held until served
- `mem_we`  in  1  1 = write
- `mem_sel`  in  DATA_W/8  byte enables
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  store data
- `mem_rdata`  out  DATA_W  load data
- `mem_stallreq`  out  1  MEM result not yet available
- `bus_req`  out  1  transaction active
- `bus_we`, `bus_sel`, `bus_addr`, `bus_wdata`  out  1/DATA_W/8/ADDR_W/DATA_W  registered transaction fields
- `bus_ack`  in  1  slave completion, one cycle
- `bus_rdata`  in  DATA_W  read data, valid with `bus_ack`
- `bus_err`  out  1  sticky watchdog-abort flag

## Operation
- States: IDLE, MEM_BUSY, IF_BUSY, IF_DISCARD.
- Done flags: `if_done` and `mem_done` mark a completed, unconsumed result.
- `mem_stallreq = mem_en & ~mem_done`.
- `if_stallreq = if_en & ~if_done`.
- IDLE:
  - If `mem_en & ~mem_done`: latch `mem_*` onto the bus, set `bus_req`, go to MEM_BUSY.
  - Else if `if_en & ~if_done & ~flush`: latch the fetch with `bus_we`=0 and all `bus_sel` bits set, go to IF_BUSY.
  - MEM always has priority over IF.
- MEM_BUSY:
  - On `bus_ack`: `mem_rdata <= bus_rdata` (reads only; writes leave it unchanged), set `mem_done`, clear `bus_req`, go to IDLE.
- IF_BUSY:
  - On `bus_ack & ~flush`: `if_data <= bus_rdata`, set `if_done`, go to IDLE.
  - On `bus_ack & flush`: drop the data, go to IDLE.
  - On `flush` without ack: go to IF_DISCARD; `bus_req` stays high because the bus cannot abort.
- IF_DISCARD:
  - On `bus_ack`: drop the data, clear `bus_req`, go to IDLE.
  - `if_stallreq` follows the formula, so a new `if_en` stalls until it is reissued from IDLE.
- Consumption:
  - `mem_done` clears on an edge where `stall[4]`=0.
  - `if_done` clears on an edge where `stall[1]`=0 or `flush`=1.
- Watchdog:
  - Counter is cleared on entry to any busy state and increments each busy cycle without ack.
  - At `TIMEOUT_CYC`: clear `bus_req` and set `bus_err`.
  - The owning port completes with data 0 and its done flag set (none for IF_DISCARD); go to IDLE.
  - `bus_err` clears only on reset.

## Timing
- Reset values:
  - state IDLE, `bus_req`/`bus_we`/`bus_err` = 0.
  - `bus_sel`/`bus_addr`/`bus_wdata`/`if_data`/`mem_rdata` = 0.
  - Done flags and counter = 0.
- Stall requests are forced to 0 while `rst` is high.
- `bus_*` are registered and change only on state-entry edges. They hold their values while busy, and hold their last values in IDLE with `bus_req`=0.
- Zero-wait slave, with the request seen in IDLE in cycle 0:
  - `bus_req` high in cycle 1, ack in cycle 1.
  - Result and done flag visible in cycle 2; stallreq low in cycle 2.
  - Throughput is one access per 2 cycles. N wait states add N cycles.
- Back-to-back: IDLE lasts exactly one cycle between transactions.
- Simultaneous MEM and IF requests: MEM is served first, then IF. IF completes at the earliest in cycle 4 with zero-wait.
- Reset mid-transaction: `bus_req` drops asynchronously and the state returns to IDLE. A late `bus_ack` in IDLE is ignored.
- `bus_ack` in IDLE is always ignored.

## Structure
- `project_types` package:
  - `bus_arb_state_t` enum (IDLE, MEM_BUSY, IF_BUSY, IF_DISCARD).
  - Existing `RST_ENABLE`/`CHIP_ENABLE` constants.
  - `BUS_TIMEOUT_DEFAULT` = 255.
- One sub-module, `bus_watchdog`:
  - Parameter `TIMEOUT_CYC`; inputs `clk`, `rst`, `clear`, `count_en`; output `expired`.
  - Counter width is `$clog2(TIMEOUT_CYC+1)`.
  - `expired` is a one-cycle pulse at the terminal count.

## Test plan
- **Zero-wait fetch:** `if_en`=1, `if_addr`=0x0000_0040, slave acks the cycle `bus_req` rises with 0x2402_0005 -> `bus_addr`=0x40 in cycle 1, `if_data`=0x2402_0005 and `if_stallreq`=0 in cycle 2.
- **Contention:** `if_en` and `mem_en` (write, `mem_sel`=4'b0011, `mem_addr`=0x100, `mem_wdata`=0xBEEF) in the same cycle -> the write goes to the bus first, then the fetch; `if_stallreq` stays high until cycle 4.
- **Flush during wait-stated fetch:** slave with 3 wait states, `flush` pulsed in the first busy cycle -> state IF_DISCARD, `bus_req` held until ack, `if_data` unchanged, new fetch issued after IDLE.
- **Consumption hold:** load completes with `stall[4]`=1 held 3 more cycles -> `mem_done` and `mem_rdata` stable, no new bus request for MEM until `stall[4]`=0.
- **Watchdog:** `TIMEOUT_CYC`=8, slave never acks a load -> `bus_req` drops after 8 busy cycles, `bus_err`=1, `mem_rdata`=0, `mem_stallreq`=0; `bus_err` stays 1 until `rst`.
- **Async reset mid-transaction:** `rst` asserted between edges while in MEM_BUSY -> `bus_req`=0 immediately, all outputs at reset values, a subsequent ack is ignored.
